// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns EX/MEM load/store controls into a
// req/ack transaction on a multi-cycle data memory, stalling the pipeline until it completes.
module mem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] ALU_rst_i,
    input  logic [DATA_W-1:0] writeData_i,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [DATA_W-1:0] readData_o,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              err_o
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             acc;
    logic             al;
    logic             launch;

    assign acc    = MemRead_i | MemWrite_i;
    assign al     = (ALU_rst_i[1:0] == 2'b00);
    assign launch = (state == IDLE) && start_i && acc && al;

    // The launch cycle itself already freezes EX/MEM so the operands stay put.
    assign stall_o    = launch || (state == ACCESS);
    assign misalign_o = (state == IDLE) && start_i && acc && !al;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            count      <= '0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            err_o      <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            readData_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        mem_addr_o <= ALU_rst_i;
                        mem_data_o <= writeData_i;
                        mem_we_o   <= MemWrite_i;
                        mem_req_o  <= 1'b1;
                        err_o      <= 1'b0;
                        count      <= '0;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    count <= count + 1'b1;
                    // An ack on the final allowed cycle still counts as success.
                    if (mem_ack_i) begin
                        if (!mem_we_o) begin
                            readData_o <= mem_data_i;
                        end
                        err_o     <= 1'b0;
                        mem_req_o <= 1'b0;
                        state     <= DONE;
                    end else if (count == CNT_LAST) begin
                        err_o      <= 1'b1;
                        readData_o <= '0;
                        mem_req_o  <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // The old instruction is still presented here; never relaunch it.
                    count <= '0;
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                    count     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios then randomized transactions,
// each checked cycle by cycle against a transaction-level reference model.
module tb_mem_access_ctrl;

    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          MemRead_i;
    logic          MemWrite_i;
    logic [DW-1:0] ALU_rst_i;
    logic [DW-1:0] writeData_i;
    logic          mem_ack_i;
    logic [DW-1:0] mem_data_i;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [DW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [DW-1:0] readData_o;
    logic          stall_o;
    logic          misalign_o;
    logic          err_o;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_rd;
    logic          exp_err;

    always #5 clk_i = ~clk_i;

    mem_access_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .ALU_rst_i(ALU_rst_i), .writeData_i(writeData_i),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .readData_o(readData_o), .stall_o(stall_o),
        .misalign_o(misalign_o), .err_o(err_o)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        start_i     = 1'b0;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        mem_ack_i   = 1'b0;
        mem_data_i  = $urandom;
    endtask

    // Full transaction: launch cycle, n ACCESS cycles, one DONE cycle.
    // ack_at in 1..TO acks on that ACCESS cycle; anything else means no ack.
    task automatic access(input bit we, input bit rd_too, input logic [DW-1:0] addr,
                          input logic [DW-1:0] wdata, input int ack_at,
                          input logic [DW-1:0] adata, input bit spurious);
        bit acked;
        int n;
        acked = (ack_at >= 1) && (ack_at <= TO);
        n     = acked ? ack_at : TO;

        start_i     = 1'b1;
        MemRead_i   = we ? rd_too : 1'b1;
        MemWrite_i  = we;
        ALU_rst_i   = addr;
        writeData_i = wdata;
        mem_ack_i   = 1'b0;
        #1;
        chk("launch_stall", stall_o, 1);
        chk("launch_req", mem_req_o, 0);
        chk("launch_misalign", misalign_o, 0);
        @(negedge clk_i);

        for (int i = 1; i <= n; i++) begin
            start_i    = 1'($urandom_range(0, 1));
            mem_ack_i  = acked && (i == ack_at);
            mem_data_i = mem_ack_i ? adata : $urandom;
            #1;
            chk("acc_req", mem_req_o, 1);
            chk("acc_stall", stall_o, 1);
            chk("acc_we", mem_we_o, we);
            chk("acc_addr", mem_addr_o, addr);
            chk("acc_wdata", mem_data_o, wdata);
            chk("acc_err_cleared", err_o, 0);
            chk("acc_rd_hold", readData_o, exp_rd);
            @(negedge clk_i);
        end

        if (acked) begin
            if (!we) exp_rd = adata;
            exp_err = 1'b0;
        end else begin
            exp_rd  = '0;
            exp_err = 1'b1;
        end

        start_i    = 1'b1;
        mem_ack_i  = spurious;
        mem_data_i = $urandom;
        #1;
        chk("done_req", mem_req_o, 0);
        chk("done_stall", stall_o, 0);
        chk("done_rd", readData_o, exp_rd);
        chk("done_err", err_o, exp_err);
        @(negedge clk_i);
        clear_inputs();
    endtask

    task automatic misaligned(input bit we, input logic [DW-1:0] addr);
        start_i    = 1'b1;
        MemRead_i  = !we;
        MemWrite_i = we;
        ALU_rst_i  = addr;
        #1;
        chk("mis_flag", misalign_o, 1);
        chk("mis_stall", stall_o, 0);
        chk("mis_req", mem_req_o, 0);
        @(negedge clk_i);
        clear_inputs();
        #1;
        chk("mis_after_req", mem_req_o, 0);
        chk("mis_after_err", err_o, exp_err);
        chk("mis_after_rd", readData_o, exp_rd);
        @(negedge clk_i);
    endtask

    task automatic no_launch(input bit memop);
        start_i    = !memop;
        MemRead_i  = memop;
        MemWrite_i = 1'b0;
        ALU_rst_i  = {$urandom} & 32'hFFFF_FFFC;
        #1;
        chk("nl_stall", stall_o, 0);
        chk("nl_misalign", misalign_o, 0);
        @(negedge clk_i);
        clear_inputs();
        #1;
        chk("nl_req", mem_req_o, 0);
        @(negedge clk_i);
    endtask

    initial begin
        rst_i       = 1'b0;
        ALU_rst_i   = '0;
        writeData_i = '0;
        clear_inputs();
        exp_rd      = '0;
        exp_err     = 1'b0;
        #1;
        chk("rst_req", mem_req_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wdata", mem_data_o, 0);
        chk("rst_rd", readData_o, 0);
        chk("rst_stall", stall_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        access(1'b0, 1'b0, 32'h0000_0010, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 1, 32'hCAFE_0000, 1'b0);
        chk("store_keeps_rd", readData_o, 32'hDEAD_BEEF);
        misaligned(1'b0, 32'h0000_0013);
        access(1'b0, 1'b0, 32'h0000_0030, 32'h0, 0, 32'h0, 1'b0);
        chk("timeout_err", err_o, 1);
        access(1'b0, 1'b0, 32'h0000_0034, 32'h0, 2, 32'h0BAD_F00D, 1'b0);
        chk("err_cleared", err_o, 0);
        access(1'b1, 1'b1, 32'h0000_0038, 32'hA5A5_5A5A, TO, 32'h0, 1'b0);

        start_i   = 1'b1;
        MemRead_i = 1'b1;
        ALU_rst_i = 32'h0000_0050;
        @(negedge clk_i);
        #1;
        chk("rst_mid_req_before", mem_req_o, 1);
        @(negedge clk_i);
        rst_i   = 1'b0;
        start_i = 1'b0;
        #1;
        exp_rd  = '0;
        exp_err = 1'b0;
        chk("rst_mid_req", mem_req_o, 0);
        chk("rst_mid_stall", stall_o, 0);
        chk("rst_mid_rd", readData_o, 0);
        chk("rst_mid_addr", mem_addr_o, 0);
        @(negedge clk_i);
        rst_i      = 1'b1;
        MemRead_i  = 1'b0;
        mem_ack_i  = 1'b1;
        mem_data_i = 32'hFFFF_0001;
        #1;
        chk("late_ack_req", mem_req_o, 0);
        @(negedge clk_i);
        clear_inputs();
        #1;
        chk("late_ack_rd", readData_o, 0);
        chk("late_ack_err", err_o, 0);
        chk("late_ack_req2", mem_req_o, 0);
        @(negedge clk_i);
        access(1'b0, 1'b0, 32'h0000_0050, 32'h0, 2, 32'h5555_AAAA, 1'b0);

        access(1'b0, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h1111_2222, 1'b1);
        access(1'b0, 1'b0, 32'h0000_0044, 32'h0, 1, 32'h3333_4444, 1'b0);

        no_launch(1'b0);
        no_launch(1'b1);

        for (int t = 0; t < 30; t++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                misaligned(1'($urandom_range(0, 1)), {$urandom} | 32'h1);
            end else if (kind == 1) begin
                no_launch(1'($urandom_range(0, 1)));
            end else begin
                access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       {$urandom} & 32'hFFFF_FFFC, $urandom,
                       int'($urandom_range(1, TO + 3)), $urandom,
                       1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
